tile_loop_controller: RTL
=========================

# tile_loop_controller

Sequences the spatial tile loop for one input-depth pass of the Winograd convolution. On each `data_prepare_i` request from the main controller it walks the block grid in raster order and issues one tile request per block to the data buffer over a valid/ready handshake. It tracks tiles in flight to the PE array and pulses `loop_finished_o` once every issued tile has been reported done.

## Interface
- `MAX_OUTSTANDING`, default 4: maximum tiles issued but not yet reported done; must be 1–15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data_prepare_i`  in  1  pass request from the main controller; level signal.
- `block_width_i`  in  8  blocks per row. 0 is treated as 1.
- `block_height_i`  in  8  blocks per column. 0 is treated as 1.
- `data_id_i`  in  4  input-depth index for this pass.
- `size_type_i`  in  1  tile step select: 1 gives step 4, 0 gives step 6.
- `tile_valid_o`  out  1  tile request valid.
- `tile_ready_i`  in  1  data buffer accepts the request.
- `tile_x_o`  out  9  pixel x origin of the tile.
- `tile_y_o`  out  9  pixel y origin of the tile.
- `tile_id_o`  out  4  latched `data_id_i`.
- `pe_done_i`  in  1  single-cycle pulse; one issued tile has completed.
- `loop_finished_o`  out  1  single-cycle pulse; the pass is complete.
- `busy_o`  out  1  high in any state other than IDLE.
- `err_o`  out  1  sticky flag for a protocol error; cleared only by reset.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE, WAIT_LOW.
- **IDLE**
  - If `data_prepare_i`=1, latch width, height (0 becomes 1), id, and step.
  - Clear bx, by, `tile_x_o`, and `tile_y_o` to 0, then go to ISSUE.
- **ISSUE**
  - `tile_valid_o` = 1 exactly when outstanding < `MAX_OUTSTANDING`.
  - On handshake (`tile_valid_o` and `tile_ready_i` both high), outstanding increments.
  - If bx < width−1: bx += 1 and x += step.
  - Otherwise bx = 0, x = 0, by += 1, and y += step.
  - On handshake of the last tile (bx = width−1 and by = height−1), go to DRAIN.
- **DRAIN**
  - Go to DONE when the next outstanding value is 0.
- **DONE**
  - `loop_finished_o` = 1 for this single cycle, then go to WAIT_LOW.
- **WAIT_LOW**
  - Go to IDLE when `data_prepare_i` = 0. This prevents a stale level from restarting a pass.
- Outstanding counter:
  - A handshake and a `pe_done_i` in the same cycle leave it unchanged.
  - `pe_done_i` is honoured in every state.
  - `pe_done_i` while outstanding = 0 with no handshake in the same cycle: counter holds at 0 and `err_o` is set.
- Arithmetic:
  - x and y are 9-bit accumulators and wrap modulo 512.
  - Callers keep the grid extent ≤ 511.
- Input handling:
  - Inputs are sampled only in IDLE.
  - Changes to `data_prepare_i` or the configuration inputs during ISSUE or DRAIN are ignored.
- `tile_x_o`, `tile_y_o`, and `tile_id_o` stay stable while `tile_valid_o`=1 and `tile_ready_i`=0.

## Timing
- Reset values:
  - State IDLE.
  - Every output 0.
  - bx, by, and the outstanding count 0.
- Start latency: `data_prepare_i` is sampled high at edge N; `tile_valid_o` is high in cycle N+1.
- Issue rate: with `tile_ready_i` held at 1 and no outstanding stall, one tile per cycle with zero bubbles.
- 1×1 minimum pass:
  - Accept at edge N+1.
  - `pe_done_i` in cycle N+2 gives DONE at edge N+2.
  - `loop_finished_o` is high in cycle N+3.
  - WAIT_LOW from edge N+3.
- The full-credit stall takes effect in the same cycle: `tile_valid_o` drops combinationally from the registered count.
- Reset asserted mid-pass immediately returns the block to IDLE with all counters cleared. In-flight `pe_done_i` pulses after reset count as errors.

## Structure
- Shared package `winocnn_pkg` holds:
  - the `tile_state_t` enum;
  - `STEP_F4` = 4 and `STEP_F6` = 6;
  - `COORD_W` = 9.
- One sub-module, `tile_coord_gen`:
  - Contains the bx/by counters and the x/y accumulators.
  - Inputs: clear and advance.
  - Outputs: `last` and the coordinates.
- The FSM and the outstanding counter stay in the top module.

## Test plan
- **4×3 grid, step 4, ready=1, immediate done:**
  - Stimulus: width=4, height=3, size_type=1, `tile_ready_i`=1, `pe_done_i` one cycle after each accept.
  - Required: 12 tiles, (0,0),(4,0),(8,0),(12,0),(0,4)…(12,8); `tile_id_o`=id.
  - Required: exactly one `loop_finished_o` pulse.
- **Backpressure:**
  - Stimulus: `tile_ready_i` toggles 1-0-1.
  - Required: coordinates hold while ready=0; no tile skipped or duplicated.
- **Credit stall, MAX_OUTSTANDING=2, no `pe_done_i`:**
  - Required: exactly 2 tiles accepted, then `tile_valid_o`=0.
  - Stimulus: one `pe_done_i`. Required: the third tile issues the next cycle.
- **Simultaneous events:** a handshake and `pe_done_i` in the same cycle leave outstanding unchanged.
- **Zero-size grid:**
  - Stimulus: width=0, height=0, size_type=0.
  - Required: a single tile (0,0) and a `loop_finished_o` pulse.
- **Rearm and error handling:**
  - Rearm: hold `data_prepare_i` high after DONE. Required: no second pass until it drops for ≥1 cycle.
  - Stray done: `pe_done_i` in IDLE. Required: `err_o`=1.
  - Reset mid-ISSUE. Required: all outputs 0 and `err_o` cleared.

Source files
------------

// File: rtl/winocnn_pkg.sv
// Shared types and constants for the Winograd convolution control blocks.
package winocnn_pkg;
  localparam int COORD_W = 9;
  localparam int STEP_F4 = 4;
  localparam int STEP_F6 = 6;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE,
    WAIT_LOW
  } tile_state_t;

  typedef struct packed {
    logic [7:0]         width_m1;
    logic [7:0]         height_m1;
    logic [3:0]         id;
    logic [COORD_W-1:0] step;
  } tile_cfg_t;
endpackage

// File: rtl/tile_coord_gen.sv
// Raster-order block counters with matching pixel-origin accumulators.
module tile_coord_gen
  import winocnn_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               advance_i,
  input  logic [7:0]         width_m1_i,
  input  logic [7:0]         height_m1_i,
  input  logic [COORD_W-1:0] step_i,
  output logic               last_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o
);
  logic [7:0]         bx_q, bx_d, by_q, by_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

  always_comb begin
    bx_d = bx_q;
    by_d = by_q;
    x_d  = x_q;
    y_d  = y_q;
    if (clear_i) begin
      bx_d = '0;
      by_d = '0;
      x_d  = '0;
      y_d  = '0;
    end else if (advance_i) begin
      if (bx_q < width_m1_i) begin
        bx_d = bx_q + 8'd1;
        x_d  = x_q + step_i;
      end else begin
        bx_d = '0;
        x_d  = '0;
        by_d = by_q + 8'd1;
        y_d  = y_q + step_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bx_q <= '0;
      by_q <= '0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      bx_q <= bx_d;
      by_q <= by_d;
      x_q  <= x_d;
      y_q  <= y_d;
    end
  end

  assign last_o = (bx_q == width_m1_i) && (by_q == height_m1_i);
  assign x_o    = x_q;
  assign y_o    = y_q;
endmodule

// File: rtl/tile_loop_controller.sv
// Spatial tile loop for one input-depth pass: issues tiles in raster order
// under a credit limit and signals completion once every tile is reported done.
module tile_loop_controller
  import winocnn_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data_prepare_i,
  input  logic [7:0]         block_width_i,
  input  logic [7:0]         block_height_i,
  input  logic [3:0]         data_id_i,
  input  logic               size_type_i,
  output logic               tile_valid_o,
  input  logic               tile_ready_i,
  output logic [COORD_W-1:0] tile_x_o,
  output logic [COORD_W-1:0] tile_y_o,
  output logic [3:0]         tile_id_o,
  input  logic               pe_done_i,
  output logic               loop_finished_o,
  output logic               busy_o,
  output logic               err_o
);
  tile_state_t state_q, state_d;
  tile_cfg_t   cfg_q, cfg_d;
  logic [3:0]  out_q, out_d;
  logic        err_q, err_d;
  logic        clear, hs, last;

  tile_coord_gen u_coord (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (clear),
    .advance_i  (hs),
    .width_m1_i (cfg_q.width_m1),
    .height_m1_i(cfg_q.height_m1),
    .step_i     (cfg_q.step),
    .last_o     (last),
    .x_o        (tile_x_o),
    .y_o        (tile_y_o)
  );

  // Credit stall is taken from the registered count so valid never depends on ready.
  assign tile_valid_o = (state_q == ISSUE) && (out_q < 4'(MAX_OUTSTANDING));
  assign hs           = tile_valid_o && tile_ready_i;

  always_comb begin
    out_d = out_q;
    err_d = err_q;
    if (hs && !pe_done_i) begin
      out_d = out_q + 4'd1;
    end else if (!hs && pe_done_i) begin
      if (out_q == 4'd0) err_d = 1'b1;
      else               out_d = out_q - 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_prepare_i) begin
          cfg_d.width_m1  = (block_width_i  == 8'd0) ? 8'd0 : block_width_i  - 8'd1;
          cfg_d.height_m1 = (block_height_i == 8'd0) ? 8'd0 : block_height_i - 8'd1;
          cfg_d.id        = data_id_i;
          cfg_d.step      = size_type_i ? COORD_W'(STEP_F4) : COORD_W'(STEP_F6);
          clear           = 1'b1;
          state_d         = ISSUE;
        end
      end
      ISSUE:    if (hs && last)     state_d = DRAIN;
      DRAIN:    if (out_d == 4'd0)  state_d = DONE;
      DONE:                         state_d = WAIT_LOW;
      WAIT_LOW: if (!data_prepare_i) state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign tile_id_o       = cfg_q.id;
  assign loop_finished_o = (state_q == DONE);
  assign busy_o          = (state_q != IDLE);
  assign err_o           = err_q;
endmodule
